// File: rtl/tow_button_cond.sv
// Two-player button conditioner: 2-flop synchronizers, slowen-strobed debounce, one-clk press pulses.
// Optional macro TIE_CANCEL_EN: simultaneous rises give a single tie pulse and suppress both presses.
module tow_button_cond #(
    parameter int STABLE_CNT = 4,
    parameter int CNT_W      = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic slowen,
    input  logic btn_l_raw,
    input  logic btn_r_raw,
    output logic press_l,
    output logic press_r,
    output logic held_l,
    output logic held_r,
    output logic tie
);
    // Comparing against STABLE_CNT-1 keeps the test free of cnt+1 overflow.
    localparam logic [CNT_W-1:0] TERM_M1 = CNT_W'(STABLE_CNT - 1);

    // Bit 0 is the left player, bit 1 the right player.
    logic [1:0]       meta_q, meta_d;
    logic [1:0]       sync_q, sync_d;
    logic [1:0]       held_q, held_d;
    logic [1:0]       held_dly_q, held_dly_d;
    logic [1:0]       press_q, press_d;
    logic [1:0]       rise;
    logic             tie_q, tie_d;
    logic [CNT_W-1:0] cnt_q [2];
    logic [CNT_W-1:0] cnt_d [2];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            meta_q     <= '0;
            sync_q     <= '0;
            held_q     <= '0;
            held_dly_q <= '0;
            press_q    <= '0;
            tie_q      <= 1'b0;
            cnt_q      <= '{default: '0};
        end else begin
            meta_q     <= meta_d;
            sync_q     <= sync_d;
            held_q     <= held_d;
            held_dly_q <= held_dly_d;
            press_q    <= press_d;
            tie_q      <= tie_d;
            cnt_q      <= cnt_d;
        end
    end

    always_comb begin
        meta_d = {btn_r_raw, btn_l_raw};
        sync_d = meta_q;
        held_d = held_q;
        cnt_d  = cnt_q;
        if (slowen) begin
            for (int i = 0; i < 2; i++) begin
                if (sync_q[i] == held_q[i]) begin
                    cnt_d[i] = '0;
                end else if (cnt_q[i] == TERM_M1) begin
                    held_d[i] = sync_q[i];
                    cnt_d[i]  = '0;
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    // Edge detect on the debounced level; the delayed copy tracks every clk so pulses are one cycle wide.
    always_comb begin
        held_dly_d = held_q;
        rise       = held_q & ~held_dly_q;
`ifdef TIE_CANCEL_EN
        tie_d   = &rise;
        press_d = (&rise) ? 2'b00 : rise;
`else
        tie_d   = 1'b0;
        press_d = rise;
`endif
    end

    assign press_l = press_q[0];
    assign press_r = press_q[1];
    assign held_l  = held_q[0];
    assign held_r  = held_q[1];
    assign tie     = tie_q;
endmodule

// File: tb/tb_tow_button_cond.sv
// Bench for tow_button_cond: vector table, corner-case sequences and random stimulus against a sample-history model.
module tb_tow_button_cond;
    localparam int N = 4;
`ifdef TIE_CANCEL_EN
    localparam bit TIE = 1'b1;
`else
    localparam bit TIE = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst, slowen, btn_l_raw, btn_r_raw;
    logic press_l, press_r, held_l, held_r, tie;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    tow_button_cond #(.STABLE_CNT(N), .CNT_W(3)) dut (
        .clk(clk), .rst(rst), .slowen(slowen),
        .btn_l_raw(btn_l_raw), .btn_r_raw(btn_r_raw),
        .press_l(press_l), .press_r(press_r),
        .held_l(held_l), .held_r(held_r), .tie(tie)
    );

    // Model: raw pipeline, debounced level, and the list of samples taken since the level last changed.
    bit [1:0] m_meta, m_sync, m_held, m_prev, m_press;
    bit       m_tie;
    bit       hq_l[$];
    bit       hq_r[$];

    function automatic bit last_n_differ(input bit q[$], input bit h);
        if (q.size() < N) return 1'b0;
        for (int k = q.size() - N; k < q.size(); k++)
            if (q[k] == h) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_reset();
        m_meta = '0; m_sync = '0; m_held = '0; m_prev = '0; m_press = '0; m_tie = 1'b0;
        hq_l.delete(); hq_r.delete();
    endtask

    task automatic model_update(input bit bl, input bit br, input bit se);
        bit [1:0] r;
        if (!rst) begin
            model_reset();
            return;
        end
        r      = m_held & ~m_prev;
        m_prev = m_held;
        if (TIE && (r == 2'b11)) begin
            m_press = 2'b00; m_tie = 1'b1;
        end else begin
            m_press = r; m_tie = 1'b0;
        end
        if (se) begin
            hq_l.push_back(m_sync[0]);
            hq_r.push_back(m_sync[1]);
            if (hq_l.size() > N) void'(hq_l.pop_front());
            if (hq_r.size() > N) void'(hq_r.pop_front());
            if (last_n_differ(hq_l, m_held[0])) begin m_held[0] = m_sync[0]; hq_l.delete(); end
            if (last_n_differ(hq_r, m_held[1])) begin m_held[1] = m_sync[1]; hq_r.delete(); end
        end
        m_sync = m_meta;
        m_meta = {br, bl};
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [4:0] outs();
        return {held_l, held_r, press_l, press_r, tie};
    endfunction

    task automatic step(input bit bl, input bit br, input bit se);
        btn_l_raw = bl; btn_r_raw = br; slowen = se;
        @(posedge clk);
        model_update(bl, br, se);
        #1;
        check("model{hl,hr,pl,pr,tie}", 32'(outs()), 32'({m_held[0], m_held[1], m_press[0], m_press[1], m_tie}));
    endtask

    task automatic do_reset();
        rst = 1'b0;
        model_reset();
        step(0, 0, 0);
        step(0, 0, 0);
        rst = 1'b1;
    endtask

    typedef struct {
        bit bl, br;
        bit hl, hr, pl, pr, t;
    } vec_t;
    vec_t vt[22];

    initial begin
        int hl_idx, pl_cnt, pr_cnt, tie_cnt, pl_idx, hr_idx, pr_idx, mode;
        bit bl, br, se;

        rst = 1'b0; slowen = 1'b0; btn_l_raw = 1'b0; btn_r_raw = 1'b0;
        model_reset();

        // Reset with both buttons high: outputs stay 0.
        for (int i = 0; i < 3; i++) step(1, 1, 1);
        check("reset_outs", 32'(outs()), 32'd0);

        // Release reset with both held and slowen constant high.
        for (int i = 0; i < 22; i++) vt[i] = '{1, 1, 0, 0, 0, 0, 0};
        vt[5] = '{1, 1, 1, 1, 0, 0, 0};
        vt[6] = '{1, 1, 1, 1, !TIE, !TIE, TIE};
        vt[7] = '{1, 1, 1, 1, 0, 0, 0};
        for (int i = 8; i < 13; i++) vt[i] = '{0, 1, 1, 1, 0, 0, 0};
        vt[13] = '{0, 1, 0, 1, 0, 0, 0};
        for (int i = 14; i < 19; i++) vt[i] = '{1, 1, 0, 1, 0, 0, 0};
        vt[19] = '{1, 1, 1, 1, 0, 0, 0};
        vt[20] = '{1, 1, 1, 1, 1, 0, 0};
        vt[21] = '{1, 1, 1, 1, 0, 0, 0};
        rst = 1'b1;
        for (int i = 0; i < 22; i++) begin
            step(vt[i].bl, vt[i].br, 1'b1);
            check($sformatf("vec[%0d]", i), 32'(outs()),
                  32'({vt[i].hl, vt[i].hr, vt[i].pl, vt[i].pr, vt[i].t}));
        end

        // Asynchronous reset takes effect between clock edges.
        #2 rst = 1'b0;
        model_reset();
        #1 check("async_reset", 32'(outs()), 32'd0);
        step(0, 0, 0);
        rst = 1'b1;

        // Clean left press with a 1-in-256 slowen strobe.
        do_reset();
        hl_idx = -1; pl_idx = -1; pl_cnt = 0; pr_cnt = 0;
        for (int i = 0; i < 256 * 5; i++) begin
            step(1, 0, (i % 256) == 255);
            if (held_l && hl_idx < 0) hl_idx = i;
            if (press_l) begin pl_cnt++; pl_idx = i; end
            if (press_r) pr_cnt++;
        end
        check("div_held_idx", 32'(hl_idx), 32'd1023);
        check("div_press_idx", 32'(pl_idx), 32'd1024);
        check("div_press_cnt", 32'(pl_cnt), 32'd1);
        check("div_press_r_cnt", 32'(pr_cnt), 32'd0);

        // Right bounce: samples 1,1,1,0,1,1,1,1 -> level rises at the 8th sample.
        do_reset();
        hr_idx = -1; pr_idx = -1; pr_cnt = 0;
        for (int i = 0; i < 16; i++) begin
            step(0, i != 3, 1);
            if (held_r && hr_idx < 0) hr_idx = i;
            if (press_r) begin pr_cnt++; pr_idx = i; end
        end
        check("bounce_held_idx", 32'(hr_idx), 32'd9);
        check("bounce_press_idx", 32'(pr_idx), 32'd10);
        check("bounce_press_cnt", 32'(pr_cnt), 32'd1);

        // Simultaneous press.
        do_reset();
        pl_cnt = 0; pr_cnt = 0; tie_cnt = 0;
        for (int i = 0; i < 12; i++) begin
            step(1, 1, 1);
            pl_cnt += int'(press_l); pr_cnt += int'(press_r); tie_cnt += int'(tie);
        end
        check("sim_press_l", 32'(pl_cnt), TIE ? 32'd0 : 32'd1);
        check("sim_press_r", 32'(pr_cnt), TIE ? 32'd0 : 32'd1);
        check("sim_tie", 32'(tie_cnt), TIE ? 32'd1 : 32'd0);
        check("sim_held", 32'({held_l, held_r}), 32'd3);

        // Reset after three qualifying samples: a full fresh qualification is needed.
        do_reset();
        for (int i = 0; i < 5; i++) step(1, 0, 1);
        #2 rst = 1'b0;
        model_reset();
        step(1, 0, 1);
        step(1, 0, 1);
        rst = 1'b1;
        hl_idx = -1; pl_idx = -1;
        for (int i = 0; i < 10; i++) begin
            step(1, 0, 1);
            if (held_l && hl_idx < 0) hl_idx = i;
            if (press_l) pl_idx = i;
        end
        check("midq_held_idx", 32'(hl_idx), 32'd5);
        check("midq_press_idx", 32'(pl_idx), 32'd6);

        // Random buttons and strobe patterns against the model.
        do_reset();
        bl = 0; br = 0; mode = 0;
        for (int i = 0; i < 6000; i++) begin
            if (i % 500 == 0) mode = $urandom_range(0, 2);
            if ($urandom_range(0, 9) == 0) bl = ~bl;
            if ($urandom_range(0, 9) == 0) br = ~br;
            if ($urandom_range(0, 60) == 0) br = bl;
            case (mode)
                0:       se = 1'b1;
                1:       se = $urandom_range(0, 1) == 1;
                default: se = (i % 8) == 0;
            endcase
            if ($urandom_range(0, 799) == 0) begin
                #2 rst = 1'b0;
                model_reset();
                #1 check("rand_async_reset", 32'(outs()), 32'd0);
                step(bl, br, se);
                rst = 1'b1;
            end
            step(bl, br, se);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/tow_button_cond.md
# tow_button_cond

Two-player button conditioner for the tug-of-war game. Sits directly downstream of the 1-in-256 slow-enable divider. It synchronizes the two raw player buttons to `clk` and debounces them, using the divider's `slowen` pulse as the sample strobe. It emits single-cycle press pulses that the game FSM consumes to move the rope marker.

## Interface
- `STABLE_CNT`, default 4: consecutive `slowen` samples of a new level required before the debounced level changes; legal range 1..(2^CNT_W − 1).
- `CNT_W`, default 3: width of each channel's stability counter.
- `clk` input 1: system clock; all flops on rising edge.
- `rst` input 1: asynchronous, active-low reset (asserted when 0).
- `slowen` input 1: sample strobe from divider; one-clk-wide high pulse, any spacing including constant high.
- `btn_l_raw` input 1: left player button, asynchronous, active-high.
- `btn_r_raw` input 1: right player button, asynchronous, active-high.
- `press_l` output 1: one-clk pulse on debounced left press (0→1).
- `press_r` output 1: one-clk pulse on debounced right press.
- `held_l` output 1: debounced left level.
- `held_r` output 1: debounced right level.
- `tie` output 1: one-clk pulse when both debounced presses occur on the same sample (see Configuration).

## Operation
- Per channel, a two-flop synchronizer runs on every `clk`, independent of `slowen`, producing `sync_x`.
- Per channel state: `held_x` (stable level) and a `CNT_W`-bit counter `cnt_x`. These update only on clk edges where `slowen`=1.
- If `sync_x` ≠ `held_x` and `cnt_x`+1 == `STABLE_CNT`: set `held_x` ← `sync_x`, `cnt_x` ← 0.
- If `sync_x` ≠ `held_x` otherwise: `cnt_x` ← `cnt_x`+1.
- If `sync_x` == `held_x`: `cnt_x` ← 0. Any bounce restarts qualification.
- The counter never wraps. The legal `STABLE_CNT` range guarantees the terminal count is reached first.
- Rise event: `held_x` goes 0→1 on a sample edge. The registered `press_x` is high for exactly the next clk cycle.
- Release (1→0) is debounced identically and produces no pulse.
- Arbitration applies when both channels' rise events occur on the same sample edge (see Configuration). Rises on different sample edges are independent, even if separated by one sample.
- With `slowen`=0, `held_x`, `cnt_x` and press state hold. Pulses still self-clear after one cycle.

## Timing
- Reset (`rst`=0): `press_l`, `press_r`, `tie`, `held_l`, `held_r` = 0. Counters and synchronizer flops = 0. Effective immediately and asynchronously.
- Reset deassertion mid-qualification discards all partial counts.
- The raw-to-`sync_x` latency is 2 clks.
- `held_x` changes at the clk edge of the `STABLE_CNT`-th consecutive qualifying `slowen` sample.
- `press_x`/`tie` go high 1 clk after `held_x` changes and low 1 clk later. The width is always exactly 1 clk, even with `slowen` held high.
- Minimum press-to-press spacing is 2·`STABLE_CNT` samples (press, release, press).
- A button held through reset deassertion is treated as a new press after `STABLE_CNT` samples, because `held_x` resets to 0.

## Configuration
- `TIE_CANCEL_EN` defined:
  - Simultaneous left/right rise events suppress both `press_l` and `press_r`.
  - `tie` pulses for 1 clk instead.
  - `held_l`/`held_r` still update normally.
- `TIE_CANCEL_EN` undefined:
  - Simultaneous rises pulse both `press_l` and `press_r`.
  - `tie` is constant 0.
  - The arbitration logic is not compiled.

## Test plan
- **Reset:** `rst`=0 with both buttons high → all outputs 0. Release `rst`, `slowen` constant 1, STABLE_CNT=4 → `held_l`=`held_r`=1 after 2 sync clks + 4 sample clks. Press/tie behaviour follows the macro setting.
- **Clean left press, `slowen` from the divider (period 256):** raise `btn_l_raw` and hold.
  - `held_l` rises on the 4th `slowen` edge after sync.
  - `press_l` is high for exactly 1 clk after that edge.
  - `press_r` stays 0.
- **Bounce, `slowen` constant 1:** `btn_r_raw` sampled as 1,1,1,0,1,1,1,1 → counter resets at the 0. `held_r` rises only at the 8th sample, with a single `press_r` pulse.
- **Release:** hold left press, then drop `btn_l_raw` → `held_l` falls after 4 samples. No `press_l` pulse on the fall.
- **Simultaneous press:** raise both buttons on the same clk, `slowen` constant 1.
  - With `TIE_CANCEL_EN`: `tie`=1 for 1 clk, both press outputs 0.
  - Without it: `press_l`=`press_r`=1 for 1 clk, `tie`=0.
- **Reset mid-qualification:** assert `rst` after 3 qualifying samples, then release with the button still held → 4 fresh samples are required before `press_x`.
